// File: rtl/axis_hex_monitor.sv
// Passive AXI-Stream tap: captures live/first/count/length values from monitored beats
// and drives a registered hex value plus 7-segment patterns.
module axis_hex_monitor #(
  parameter int DIGITS      = 8,
  parameter int DATA_WIDTH  = 8,
  parameter bit INVERT      = 1'b1,
  parameter bit BLANK_ZEROS = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [2:0]            mode,
  input  logic                  freeze,
  input  logic [DIGITS*4-1:0]   static_value,
  output logic [DIGITS*4-1:0]   value_out,
  output logic [DIGITS*7-1:0]   seg_out,
  output logic                  in_frame
);
  localparam int DW = DIGITS * 4;
  localparam int NB = DW / DATA_WIDTH;

  localparam logic IDLE     = 1'b0;
  localparam logic IN_FRAME = 1'b1;

  logic          beat;
  logic          state;
  logic [DW-1:0] live_r, head_r, first_r, cnt_r, len_r, frm_r;
  logic [DW-1:0] live_next, head_next, cnt_inc;
  logic [DW-1:0] sel_val;
  logic          sel_blank, blank_r;

  assign beat     = s_axis_tvalid && s_axis_tready;
  assign in_frame = (state == IN_FRAME);
  assign cnt_inc  = (cnt_r == {DW{1'b1}}) ? cnt_r : cnt_r + DW'(1);

  generate
    if (DW > DATA_WIDTH) begin : g_shift
      assign live_next = {live_r[DW-DATA_WIDTH-1:0], s_axis_tdata};
    end else begin : g_single
      assign live_next = s_axis_tdata;
    end
  endgenerate

  // Beat k of the frame fills slot k from the MSB end; beats past the last slot are dropped.
  always_comb begin
    head_next = head_r;
    for (int j = 0; j < NB; j++) begin
      if (cnt_r == DW'(j))
        head_next[DW-1-j*DATA_WIDTH -: DATA_WIDTH] = s_axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      live_r  <= '0;
      head_r  <= '0;
      first_r <= '0;
      cnt_r   <= '0;
      len_r   <= '0;
      frm_r   <= '0;
    end else if (beat) begin
      live_r <= live_next;
      state  <= s_axis_tlast ? IDLE : IN_FRAME;
      if (s_axis_tlast) begin
        first_r <= head_next;
        head_r  <= '0;
        len_r   <= cnt_inc;
        cnt_r   <= '0;
        frm_r   <= frm_r + DW'(1);
      end else begin
        head_r <= head_next;
        cnt_r  <= cnt_inc;
      end
    end
  end

  always_comb begin
    sel_val   = '0;
    sel_blank = 1'b0;
    case (mode)
      3'd0:    sel_val = live_r;
      3'd1:    sel_val = first_r;
      3'd2:    sel_val = frm_r;
      3'd3:    sel_val = len_r;
      3'd4:    sel_val = static_value;
      default: sel_blank = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_out <= '0;
      blank_r   <= 1'b0;
    end else if (!freeze) begin
      value_out <= sel_val;
      blank_r   <= sel_blank;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Walk from the top digit so "lead" stays set only while every higher digit is zero.
  function automatic logic [DIGITS*7-1:0] encode(input logic [DW-1:0] v, input logic blank_all);
    logic       lead;
    logic [3:0] nib;
    logic [6:0] pat;
    encode = '0;
    lead   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib  = v[4*i +: 4];
      lead = lead && (nib == 4'h0);
      pat  = (blank_all || (BLANK_ZEROS && lead && (i != 0))) ? 7'h00 : hex7(nib);
      encode[7*i +: 7] = INVERT ? ~pat : pat;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) seg_out <= encode('0, 1'b0);
    else     seg_out <= encode(value_out, blank_r);
  end

endmodule

// File: tb/tb_axis_hex_monitor.sv
// Directed bench for axis_hex_monitor: 8-digit active-low display, a blank-leading-zeros
// variant and a 2-digit variant all watch the same stream.
module tb_axis_hex_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tdata;
  logic        tvalid, tready, tlast;
  logic [2:0]  mode;
  logic        freeze;
  logic [31:0] static_value;

  logic [31:0] v0, v1;
  logic [55:0] s0, s1;
  logic        f0, f1, f2;
  logic [7:0]  v2;
  logic [13:0] s2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_hex_monitor #(.DIGITS(8), .DATA_WIDTH(8), .INVERT(1'b1), .BLANK_ZEROS(1'b0)) u0 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .mode(mode), .freeze(freeze),
    .static_value(static_value), .value_out(v0), .seg_out(s0), .in_frame(f0));

  axis_hex_monitor #(.DIGITS(8), .DATA_WIDTH(8), .INVERT(1'b1), .BLANK_ZEROS(1'b1)) u1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .mode(mode), .freeze(freeze),
    .static_value(static_value), .value_out(v1), .seg_out(s1), .in_frame(f1));

  axis_hex_monitor #(.DIGITS(2), .DATA_WIDTH(8), .INVERT(1'b1), .BLANK_ZEROS(1'b0)) u2 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .mode(mode), .freeze(freeze),
    .static_value(static_value[7:0]), .value_out(v2), .seg_out(s2), .in_frame(f2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    tdata = d; tlast = last; tvalid = 1'b1; tready = 1'b1;
    tick();
    tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) send(8'(i), i == n - 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tdata = '0; tvalid = 0; tready = 0; tlast = 0;
    mode = 3'd0; freeze = 0; static_value = '0;

    // T1 reset
    tick(); tick();
    chk("rst_value", v0, 32'h0);
    chk("rst_in_frame", f0, 1'b0);
    chk("rst_seg", s0, {8{7'h40}});
    chk("rst_seg_blank", s1, {{7{7'h7F}}, 7'h40});
    chk("rst_seg_d2", s2, {2{7'h40}});
    rst = 1'b0;

    // T2 live shift
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0); send(8'h9A, 0);
    tick();
    chk("live_value", v0, 32'h3456789A);
    tick();
    chk("live_digit6", s0[48:42], 7'h19);
    chk("live_digit0", s0[6:0], 7'h08);
    chk("live_in_frame", f0, 1'b1);
    tvalid = 1'b1; tready = 1'b0; tdata = 8'hFF;
    repeat (10) tick();
    tvalid = 1'b0;
    tick();
    chk("no_ready_hold", v0, 32'h3456789A);

    // T3 first bytes
    do_reset(1);
    mode = 3'd1;
    send(8'hAA, 0);
    chk("frame_open", f0, 1'b1);
    send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    chk("frame_mid", f0, 1'b1);
    send(8'hEE, 1);
    chk("frame_closed", f0, 1'b0);
    tick();
    chk("first_5", v0, 32'hAABBCCDD);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 1);
    tick();
    chk("first_3", v0, 32'h01020300);

    // T4 counters
    do_reset(1);
    mode = 3'd2;
    frame(5); frame(1); frame(300);
    tick();
    chk("frm_count", v0, 32'h3);
    tick();
    chk("frm_seg_blank", s1, {{7{7'h7F}}, 7'h30});
    mode = 3'd3;
    tick();
    chk("len_300", v0, 32'h12C);
    chk("len_sat_d2", v2, 8'hFF);
    tick();
    chk("len_seg", s0, {{5{7'h40}}, 7'h79, 7'h24, 7'h46});
    chk("len_seg_blank", s1, {{5{7'h7F}}, 7'h79, 7'h24, 7'h46});
    do_reset(1);
    mode = 3'd2;
    repeat (257) send(8'h55, 1);
    tick();
    chk("frm_wrap_d2", v2, 8'h01);
    chk("frm_257", v0, 32'h101);

    // T5 static and freeze
    mode = 3'd4; static_value = 32'hDEADBEEF;
    tick();
    chk("static_shown", v0, 32'hDEADBEEF);
    freeze = 1'b1; static_value = 32'h0;
    tick(); tick();
    chk("freeze_hold", v0, 32'hDEADBEEF);
    freeze = 1'b0;
    tick();
    chk("freeze_release", v0, 32'h0);
    mode = 3'd6;
    tick();
    chk("mode6_value", v0, 32'h0);
    tick();
    chk("mode6_seg", s0, {8{7'h7F}});
    chk("mode6_seg_blank", s1, {8{7'h7F}});

    // T6 reset mid-frame
    mode = 3'd1;
    send(8'h11, 0); send(8'h22, 0);
    do_reset(1);
    send(8'h33, 0); send(8'h44, 1);
    tick();
    chk("rst_mid_first", v0, 32'h33440000);
    mode = 3'd2;
    tick();
    chk("rst_mid_frm", v0, 32'h1);
    mode = 3'd3;
    tick();
    chk("rst_mid_len", v0, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
